// File: rtl/anton_neopixel_stream_rx_pkg.sv
// Shared state encoding and default timing constants for the NeoPixel stream receiver.
// All timing values are counted in 7 MHz sample cycles.
package anton_neopixel_stream_rx_pkg;

   typedef enum logic [1:0] {
      ENUM_RX_STATE_SYNC  = 2'd0,
      ENUM_RX_STATE_ARMED = 2'd1,
      ENUM_RX_STATE_HIGH  = 2'd2,
      ENUM_RX_STATE_LOW   = 2'd3
   } rx_state_e;

   localparam int BUFFER_END_DEFAULT       = 15;
   localparam int RX_RESET_CYCLES_DEFAULT  = 350;
   localparam int RX_ONE_THRESHOLD_DEFAULT = 4;
   localparam int RX_HIGH_MAX_DEFAULT      = 8;

endpackage

// File: rtl/anton_neopixel_rx_sync.sv
// Two-flop synchronizer for the asynchronous data line, plus an edge-detect stage.
// Edges are defined on the synchronized line, so it lags stream_in by two cycles.
module anton_neopixel_rx_sync (
   input  logic clk7mhz,
   input  logic reset,
   input  logic stream_in,
   output logic line,
   output logic rise,
   output logic fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk7mhz) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= stream_in;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign line = r_sync;
   assign rise = r_sync & ~r_prev;
   assign fall = ~r_sync & r_prev;

endmodule

// File: rtl/anton_neopixel_stream_rx.sv
// WS2812 stream decoder: classifies bits by high-pulse width, assembles 24-bit pixels
// MSB-first, strobes each with its buffer index and reports the frame latch gap.
module anton_neopixel_stream_rx
   import anton_neopixel_stream_rx_pkg::*;
#(
   parameter  int BUFFER_END    = BUFFER_END_DEFAULT,
   parameter  int RESET_CYCLES  = RX_RESET_CYCLES_DEFAULT,
   parameter  int ONE_THRESHOLD = RX_ONE_THRESHOLD_DEFAULT,
   parameter  int HIGH_MAX      = RX_HIGH_MAX_DEFAULT,
   localparam int BUFFER_BITS   = $clog2(BUFFER_END + 1)
) (
   input  logic                   clk7mhz,
   input  logic                   reset,
   input  logic                   reg_ctrl_run,
   input  logic                   err_clear,
   input  logic                   stream_in,
   output logic [23:0]            pixel_data,
   output logic [BUFFER_BITS-1:0] pixel_index,
   output logic                   pixel_valid,
   output logic                   frame_done,
   output logic [BUFFER_BITS:0]   frame_pixels,
   output logic                   err_bit_width,
   output logic                   err_partial,
   output logic                   err_overflow,
   output logic                   rx_active
);

   localparam int LOW_W = $clog2(RESET_CYCLES + 1);
   localparam int HI_W  = $clog2(HIGH_MAX + 1);
   localparam logic [LOW_W-1:0]     LOW_LATCH = LOW_W'(RESET_CYCLES);
   localparam logic [HI_W-1:0]      HI_ONE    = HI_W'(ONE_THRESHOLD);
   localparam logic [HI_W-1:0]      HI_ERR    = HI_W'(HIGH_MAX);
   localparam logic [BUFFER_BITS:0] PIX_FULL  = (BUFFER_BITS + 1)'(BUFFER_END + 1);

   logic w_line, w_rise, w_fall;

   rx_state_e            r_state, w_state_nxt;
   logic [LOW_W-1:0]     r_low_cnt, w_low_nxt, w_low_inc;
   logic [HI_W-1:0]      r_high_cnt, w_high_nxt, w_high_inc;
   logic [4:0]           r_bit_cnt, w_bit_nxt, w_bit_inc;
   logic [23:0]          r_shift, w_shift_nxt, w_shift_in;
   logic [BUFFER_BITS:0] r_pix_cnt, w_pix_nxt;
   logic                 w_strobe, w_done, w_set_bw, w_set_part, w_set_ovf;

   anton_neopixel_rx_sync u_sync (
      .clk7mhz   (clk7mhz),
      .reset     (reset),
      .stream_in (stream_in),
      .line      (w_line),
      .rise      (w_rise),
      .fall      (w_fall)
   );

   assign w_low_inc  = r_low_cnt + 1'b1;
   assign w_high_inc = (r_high_cnt == HI_ERR) ? r_high_cnt : r_high_cnt + 1'b1;
   assign w_bit_inc  = r_bit_cnt + 1'b1;
   assign w_shift_in = {r_shift[22:0], (r_high_cnt >= HI_ONE)};

   always_comb begin
      w_state_nxt = r_state;
      w_low_nxt   = r_low_cnt;
      w_high_nxt  = r_high_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_shift_nxt = r_shift;
      w_pix_nxt   = r_pix_cnt;
      w_strobe    = 1'b0;
      w_done      = 1'b0;
      w_set_bw    = 1'b0;
      w_set_part  = 1'b0;
      w_set_ovf   = 1'b0;
      if (!reg_ctrl_run) begin
         // Holding low_cnt at 0 forces a full latch gap after re-enable.
         w_state_nxt = ENUM_RX_STATE_SYNC;
         w_low_nxt   = '0;
         w_bit_nxt   = '0;
      end else begin
         unique case (r_state)
            ENUM_RX_STATE_SYNC: begin
               if (w_line) begin
                  w_low_nxt = '0;
               end else if (w_low_inc == LOW_LATCH) begin
                  w_state_nxt = ENUM_RX_STATE_ARMED;
                  w_low_nxt   = '0;
               end else begin
                  w_low_nxt = w_low_inc;
               end
            end
            ENUM_RX_STATE_ARMED: begin
               if (w_rise) begin
                  w_state_nxt = ENUM_RX_STATE_HIGH;
                  w_high_nxt  = HI_W'(1);
                  w_pix_nxt   = '0;
                  w_bit_nxt   = '0;
               end
            end
            ENUM_RX_STATE_HIGH: begin
               if (w_fall) begin
                  w_state_nxt = ENUM_RX_STATE_LOW;
                  w_low_nxt   = LOW_W'(1);
                  w_shift_nxt = w_shift_in;
                  if (w_bit_inc == 5'd24) begin
                     w_bit_nxt = '0;
                     // Past the buffer end the index stays put and nothing is strobed.
                     if (r_pix_cnt == PIX_FULL) begin
                        w_set_ovf = 1'b1;
                     end else begin
                        w_strobe  = 1'b1;
                        w_pix_nxt = r_pix_cnt + 1'b1;
                     end
                  end else begin
                     w_bit_nxt = w_bit_inc;
                  end
               end else if (w_high_inc >= HI_ERR) begin
                  w_set_bw    = 1'b1;
                  w_state_nxt = ENUM_RX_STATE_SYNC;
                  w_low_nxt   = '0;
                  w_bit_nxt   = '0;
               end else begin
                  w_high_nxt = w_high_inc;
               end
            end
            ENUM_RX_STATE_LOW: begin
               if (w_rise) begin
                  w_state_nxt = ENUM_RX_STATE_HIGH;
                  w_high_nxt  = HI_W'(1);
               end else if (w_low_inc == LOW_LATCH) begin
                  w_done      = 1'b1;
                  w_set_part  = (r_bit_cnt != 5'd0);
                  w_bit_nxt   = '0;
                  w_low_nxt   = '0;
                  w_state_nxt = ENUM_RX_STATE_ARMED;
               end else begin
                  w_low_nxt = w_low_inc;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk7mhz) begin
      if (reset) begin
         r_state       <= ENUM_RX_STATE_SYNC;
         r_low_cnt     <= '0;
         r_high_cnt    <= '0;
         r_bit_cnt     <= '0;
         r_shift       <= '0;
         r_pix_cnt     <= '0;
         pixel_data    <= '0;
         pixel_index   <= '0;
         pixel_valid   <= 1'b0;
         frame_done    <= 1'b0;
         frame_pixels  <= '0;
         err_bit_width <= 1'b0;
         err_partial   <= 1'b0;
         err_overflow  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_low_cnt   <= w_low_nxt;
         r_high_cnt  <= w_high_nxt;
         r_bit_cnt   <= w_bit_nxt;
         r_shift     <= w_shift_nxt;
         r_pix_cnt   <= w_pix_nxt;
         pixel_valid <= w_strobe;
         frame_done  <= w_done;
         if (w_strobe) begin
            pixel_data  <= w_shift_in;
            pixel_index <= r_pix_cnt[BUFFER_BITS-1:0];
         end
         if (w_done) begin
            frame_pixels <= r_pix_cnt;
         end
         // A new error in the same cycle as err_clear wins.
         err_bit_width <= (err_bit_width & ~err_clear) | w_set_bw;
         err_partial   <= (err_partial & ~err_clear) | w_set_part;
         err_overflow  <= (err_overflow & ~err_clear) | w_set_ovf;
      end
   end

   assign rx_active = (r_state == ENUM_RX_STATE_HIGH) || (r_state == ENUM_RX_STATE_LOW);

endmodule

// File: tb/tb_anton_neopixel_stream_rx.sv
// Directed bench: a default-size receiver plus a two-pixel-buffer receiver on the same line.
module tb_anton_neopixel_stream_rx;
   import anton_neopixel_stream_rx_pkg::*;

   logic clk = 1'b0;
   logic reset, run, clr, sin;

   logic [23:0] pd_a, pd_b;
   logic [3:0]  pi_a;
   logic [0:0]  pi_b;
   logic [4:0]  fp_a;
   logic [1:0]  fp_b;
   logic pv_a, fd_a, ebw_a, ep_a, eo_a, act_a;
   logic pv_b, fd_b, ebw_b, ep_b, eo_b, act_b;

   int checks = 0;
   int errors = 0;

   logic [23:0] q_data[$];
   logic [3:0]  q_idx[$];
   int n_pv_a = 0, n_fd_a = 0, last_fp_a = 0;
   int n_pv_b = 0, last_fp_b = 0;

   always #5 clk = ~clk;

   anton_neopixel_stream_rx #(.BUFFER_END(15)) dut_a (
      .clk7mhz(clk), .reset(reset), .reg_ctrl_run(run), .err_clear(clr), .stream_in(sin),
      .pixel_data(pd_a), .pixel_index(pi_a), .pixel_valid(pv_a), .frame_done(fd_a),
      .frame_pixels(fp_a), .err_bit_width(ebw_a), .err_partial(ep_a), .err_overflow(eo_a),
      .rx_active(act_a)
   );

   anton_neopixel_stream_rx #(.BUFFER_END(1)) dut_b (
      .clk7mhz(clk), .reset(reset), .reg_ctrl_run(run), .err_clear(clr), .stream_in(sin),
      .pixel_data(pd_b), .pixel_index(pi_b), .pixel_valid(pv_b), .frame_done(fd_b),
      .frame_pixels(fp_b), .err_bit_width(ebw_b), .err_partial(ep_b), .err_overflow(eo_b),
      .rx_active(act_b)
   );

   always @(negedge clk) begin
      if (pv_a) begin
         q_data.push_back(pd_a);
         q_idx.push_back(pi_a);
         n_pv_a++;
      end
      if (fd_a) begin
         n_fd_a++;
         last_fp_a = int'(fp_a);
      end
      if (pv_b) n_pv_b++;
      if (fd_b) last_fp_b = int'(fp_b);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_w(input int hi, input int lo);
      sin = 1'b1;
      cyc(hi);
      sin = 1'b0;
      cyc(lo);
   endtask

   task automatic send_bits(input logic [23:0] v, input int n);
      for (int i = 23; i > 23 - n; i--) begin
         if (v[i]) send_w(5, 3);
         else      send_w(2, 6);
      end
   endtask

   task automatic gap();
      sin = 1'b0;
      cyc(360);
   endtask

   task automatic pulse_clear();
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      cyc(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; run = 1'b1; clr = 1'b0; sin = 1'b0;
      cyc(3);
      chk("rst_pixel_valid", 32'(pv_a), 32'd0);
      chk("rst_frame_done",  32'(fd_a), 32'd0);
      chk("rst_pixel_data",  32'(pd_a), 32'd0);
      chk("rst_pixel_index", 32'(pi_a), 32'd0);
      chk("rst_frame_pix",   32'(fp_a), 32'd0);
      chk("rst_errs",        32'({ebw_a, ep_a, eo_a}), 32'd0);
      chk("rst_rx_active",   32'(act_a), 32'd0);
      reset = 1'b0;

      // Bring-up: a short low stretch must not arm; a full gap must.
      cyc(340);
      sin = 1'b1;
      cyc(3);
      chk("short_gap_sync", 32'(dut_a.r_state), 32'(ENUM_RX_STATE_SYNC));
      gap();
      chk("gap_armed",      32'(dut_a.r_state), 32'(ENUM_RX_STATE_ARMED));
      chk("bringup_nostrb", 32'(n_pv_a), 32'd0);

      // Single pixel
      send_bits(24'hA5C33C, 24);
      gap();
      chk("single_cnt",   32'(n_pv_a), 32'd1);
      chk("single_data",  32'(q_data[0]), 32'hA5C33C);
      chk("single_idx",   32'(q_idx[0]), 32'd0);
      chk("single_frame", 32'(n_fd_a), 32'd1);
      chk("single_fpix",  32'(last_fp_a), 32'd1);
      chk("single_errs",  32'({ebw_a, ep_a, eo_a}), 32'd0);

      // Three-pixel frame; the two-entry receiver overflows on the third
      send_bits(24'hFF0000, 24);
      send_bits(24'h00FF00, 24);
      send_bits(24'h0000FF, 24);
      gap();
      chk("multi_cnt",   32'(n_pv_a), 32'd4);
      chk("multi_d0",    32'(q_data[1]), 32'hFF0000);
      chk("multi_d1",    32'(q_data[2]), 32'h00FF00);
      chk("multi_d2",    32'(q_data[3]), 32'h0000FF);
      chk("multi_i0",    32'(q_idx[1]), 32'd0);
      chk("multi_i1",    32'(q_idx[2]), 32'd1);
      chk("multi_i2",    32'(q_idx[3]), 32'd2);
      chk("multi_frame", 32'(n_fd_a), 32'd2);
      chk("multi_fpix",  32'(last_fp_a), 32'd3);
      chk("multi_noovf", 32'(eo_a), 32'd0);
      chk("ovf_strobes", 32'(n_pv_b), 32'd3);
      chk("ovf_flag",    32'(eo_b), 32'd1);
      chk("ovf_fpix",    32'(last_fp_b), 32'd2);
      pulse_clear();
      chk("ovf_cleared", 32'(eo_b), 32'd0);

      // Second frame restarts at index 0
      send_bits(24'h123456, 24);
      gap();
      chk("frame2_data", 32'(q_data[4]), 32'h123456);
      chk("frame2_idx",  32'(q_idx[4]), 32'd0);
      chk("frame2_fpix", 32'(last_fp_a), 32'd1);

      // Line stuck high mid-pixel
      send_bits(24'hF00000, 5);
      sin = 1'b1;
      cyc(10);
      chk("bw_flag",   32'(ebw_a), 32'd1);
      chk("bw_state",  32'(dut_a.r_state), 32'(ENUM_RX_STATE_SYNC));
      chk("bw_active", 32'(act_a), 32'd0);
      gap();
      chk("bw_nostrb", 32'(n_pv_a), 32'd5);
      chk("bw_nofrm",  32'(n_fd_a), 32'd3);

      // Width boundaries: 4 -> 1, 3 -> 0, 7 -> 1 (no error), 1 -> 0
      send_w(4, 4);
      send_w(3, 5);
      send_w(7, 1);
      repeat (21) send_w(1, 7);
      gap();
      chk("bnd_data",   32'(q_data[5]), 32'hA00000);
      chk("bnd_cnt",    32'(n_pv_a), 32'd6);
      chk("bw_sticky",  32'(ebw_a), 32'd1);
      chk("bnd_frame",  32'(n_fd_a), 32'd4);
      pulse_clear();
      chk("bw_cleared", 32'(ebw_a), 32'd0);

      // Partial pixel then latch gap
      send_bits(24'hABC000, 12);
      gap();
      chk("part_flag",  32'(ep_a), 32'd1);
      chk("part_frame", 32'(n_fd_a), 32'd5);
      chk("part_fpix",  32'(last_fp_a), 32'd0);
      chk("part_nostr", 32'(n_pv_a), 32'd6);

      // Run dropped mid-pixel; resumed stream is ignored until a full gap
      send_bits(24'h555555, 10);
      run = 1'b0;
      cyc(3);
      run = 1'b1;
      send_bits(24'h555555, 14);
      send_bits(24'hC0FFEE, 24);
      gap();
      chk("run_nostrb", 32'(n_pv_a), 32'd6);
      chk("run_nofrm",  32'(n_fd_a), 32'd5);
      chk("run_armed",  32'(dut_a.r_state), 32'(ENUM_RX_STATE_ARMED));
      send_bits(24'h0F0F0F, 24);
      gap();
      chk("run_data",  32'(q_data[6]), 32'h0F0F0F);
      chk("run_idx",   32'(q_idx[6]), 32'd0);
      chk("run_frame", 32'(n_fd_a), 32'd6);

      // Synchronous reset mid-pixel
      send_bits(24'hFFFFFF, 8);
      sin = 1'b1;
      reset = 1'b1;
      cyc(1);
      chk("mid_rst_data",  32'(pd_a), 32'd0);
      chk("mid_rst_fpix",  32'(fp_a), 32'd0);
      chk("mid_rst_errs",  32'({ebw_a, ep_a, eo_a}), 32'd0);
      chk("mid_rst_act",   32'(act_a), 32'd0);
      chk("mid_rst_pv",    32'(pv_a), 32'd0);
      chk("mid_rst_state", 32'(dut_a.r_state), 32'(ENUM_RX_STATE_SYNC));
      reset = 1'b0;
      sin = 1'b0;
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
